// File: rtl/rs_wakeup.sv
// Reservation-station entry storage with operand wakeup, request generation and grant-driven issue.
// Define RS_FAST_WAKEUP_EN to let same-cycle tag broadcasts raise reqs combinationally.
module rs_wakeup #(
    parameter int RS_ENTRIES = 8,
    parameter int TAG_W      = 6,
    parameter int OP_W       = 32,
    parameter int WB_PORTS   = 2,
    localparam int IDX_W     = $clog2(RS_ENTRIES),
    localparam int CNT_W     = IDX_W + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [OP_W-1:0]           disp_op,
    input  logic [TAG_W-1:0]          disp_dst_tag,
    input  logic [TAG_W-1:0]          disp_src1_tag,
    input  logic [TAG_W-1:0]          disp_src2_tag,
    input  logic                      disp_src1_rdy,
    input  logic                      disp_src2_rdy,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
    output logic [RS_ENTRIES-1:0]     reqs,
    input  logic [IDX_W-1:0]          grant,
    input  logic                      grant_valid,
    output logic                      issue_valid,
    output logic [OP_W-1:0]           issue_op,
    output logic [TAG_W-1:0]          issue_dst_tag,
    input  logic                      flush,
    output logic [CNT_W-1:0]          free_count
);

    logic [RS_ENTRIES-1:0] valid, src1_rdy, src2_rdy;
    logic [RS_ENTRIES-1:0] src1_hit, src2_hit;
    logic [OP_W-1:0]       op_mem   [RS_ENTRIES];
    logic [TAG_W-1:0]      dst_mem  [RS_ENTRIES];
    logic [TAG_W-1:0]      src1_tag [RS_ENTRIES];
    logic [TAG_W-1:0]      src2_tag [RS_ENTRIES];
    logic                  disp_src1_hit, disp_src2_hit;
    logic [IDX_W-1:0]      alloc_idx;
    logic                  disp_fire, grant_fire;

    function automatic logic tag_hit(input logic [TAG_W-1:0] tag,
                                     input logic [WB_PORTS-1:0] bvalid,
                                     input logic [WB_PORTS*TAG_W-1:0] btags);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WB_PORTS; p++)
            hit |= bvalid[p] && (btags[p*TAG_W +: TAG_W] == tag);
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            src1_hit[i] = tag_hit(src1_tag[i], wb_valid, wb_tag);
            src2_hit[i] = tag_hit(src2_tag[i], wb_valid, wb_tag);
        end
        disp_src1_hit = tag_hit(disp_src1_tag, wb_valid, wb_tag);
        disp_src2_hit = tag_hit(disp_src2_tag, wb_valid, wb_tag);
    end

    // Descending scan so the last write wins: alloc_idx ends on the lowest free slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        free_count = '0;
        alloc_idx  = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_count += CNT_W'(1);
                alloc_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RS_FAST_WAKEUP_EN
    assign reqs = valid & (src1_rdy | src1_hit) & (src2_rdy | src2_hit);
`else
    assign reqs = valid & src1_rdy & src2_rdy;
`endif

    assign disp_ready = (free_count != '0);
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign grant_fire = grant_valid && reqs[grant] && !flush;

    // The allocated slot is free, so it can never be the granted slot in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state is only ever assigned with <= so every read sees pre-edge values.
            valid    <= '0;
            src1_rdy <= '0;
            src2_rdy <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (disp_fire && alloc_idx == IDX_W'(i)) begin
                    valid[i]    <= 1'b1;
                    src1_rdy[i] <= disp_src1_rdy | disp_src1_hit;
                    src2_rdy[i] <= disp_src2_rdy | disp_src2_hit;
                end else begin
                    if (grant_fire && grant == IDX_W'(i))
                        valid[i] <= 1'b0;
                    src1_rdy[i] <= src1_rdy[i] | src1_hit[i];
                    src2_rdy[i] <= src2_rdy[i] | src2_hit[i];
                end
            end
        end
    end

    // NOTE: payload arrays have no reset; valid gates every use, so their reset value is never observed.
    always_ff @(posedge clk) begin
        if (disp_fire) begin
            op_mem[alloc_idx]   <= disp_op;
            dst_mem[alloc_idx]  <= disp_dst_tag;
            src1_tag[alloc_idx] <= disp_src1_tag;
            src2_tag[alloc_idx] <= disp_src2_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid   <= 1'b0;
            issue_op      <= '0;
            issue_dst_tag <= '0;
        end else begin
            issue_valid <= grant_fire;
            if (grant_fire) begin
                issue_op      <= op_mem[grant];
                issue_dst_tag <= dst_mem[grant];
            end
        end
    end

endmodule
